eth_tx_rewrite: RTL and testbench

Egress Ethernet header writer for the router output port lookup pipeline. It takes the forwarding decision for each packet from a metadata FIFO: next-hop DMAC, output port one-hot, and drop flag. On the first 256-bit word it rewrites the Ethernet DMAC and SMAC and sets the tuser destination port, then streams the remaining words unchanged. It sits between the lookup/decision logic and the output queues, and is the transmit-side counterpart of the ingress Ethernet header parser.

---
 rtl/eth_tx_rewrite.sv | 220 ++++++++++++++++++++++
 tb/tb_eth_tx_rewrite.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_rewrite.sv
// rtl/eth_tx_rewrite.sv - egress Ethernet DMAC/SMAC rewrite and tuser destination-port insert.
// Optional macro ETH_TX_STATS_EN adds per-class word-1 counters.
module eth_tx_rewrite #(
    parameter int C_S_AXIS_TDATA_WIDTH = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MAC_WIDTH            = 48,
    parameter int DST_PORT_POS         = 24
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic [MAC_WIDTH-1:0]              i_meta_dmac,
    input  logic [7:0]                        i_meta_oport,
    input  logic                              i_meta_drop,
    input  logic                              i_meta_valid,
    output logic                              o_meta_rd,
    input  logic [MAC_WIDTH-1:0]              i_mac0,
    input  logic [MAC_WIDTH-1:0]              i_mac1,
    input  logic [MAC_WIDTH-1:0]              i_mac2,
    input  logic [MAC_WIDTH-1:0]              i_mac3
`ifdef ETH_TX_STATS_EN
    ,
    output logic [31:0]                       o_cnt_rewritten,
    output logic [31:0]                       o_cnt_cpu,
    output logic [31:0]                       o_cnt_dropped
`endif
);

    typedef enum logic [1:0] {
        ST_WORD1,
        ST_BODY,
        ST_DROP
    } state_t;

    state_t                              state_q, state_d;
    logic [7:0]                          oport_q, oport_d;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]     tdata_q, tdata_d;
    logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   tkeep_q, tkeep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]     tuser_q, tuser_d;
    logic                                tlast_q, tlast_d;
    logic                                tvalid_q, tvalid_d;

    logic                                adv;
    logic                                in_ready;
    logic                                in_hs;
    logic                                meta_rd;
    logic [7:0]                          port_mask;
    logic                                mask_onehot;
    logic                                is_rewrite;
    logic                                is_cpu;
    logic                                is_drop;
    logic [MAC_WIDTH-1:0]                smac;

`ifdef ETH_TX_STATS_EN
    logic [31:0] cnt_rw_q, cnt_rw_d;
    logic [31:0] cnt_cpu_q, cnt_cpu_d;
    logic [31:0] cnt_drop_q, cnt_drop_d;
`endif

    // Even oport bits select a physical MAC; odd bits are CPU queues.
    always_comb begin
        port_mask   = i_meta_oport & 8'h55;
        mask_onehot = (port_mask != 8'h00) && ((port_mask & (port_mask - 8'h01)) == 8'h00);
        is_rewrite  = !i_meta_drop && mask_onehot;
        is_cpu      = !i_meta_drop && (port_mask == 8'h00) && (i_meta_oport != 8'h00);
        is_drop     = !is_rewrite && !is_cpu;
        smac        = i_mac0;
        case (port_mask)
            8'h04:   smac = i_mac1;
            8'h10:   smac = i_mac2;
            8'h40:   smac = i_mac3;
            default: smac = i_mac0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        oport_d  = oport_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        meta_rd  = 1'b0;
        adv      = !tvalid_q || m_axis_tready;

        case (state_q)
            ST_WORD1: in_ready = adv && i_meta_valid;
            ST_BODY:  in_ready = adv;
            ST_DROP:  in_ready = 1'b1;
            default:  in_ready = 1'b0;
        endcase
        if (reset) begin
            in_ready = 1'b0;
        end
        in_hs = s_axis_tvalid && in_ready;

        if (adv) begin
            tvalid_d = 1'b0;
        end

        if (in_hs) begin
            case (state_q)
                ST_WORD1: begin
                    meta_rd = 1'b1;
                    oport_d = i_meta_oport;
                    if (!is_drop) begin
                        tdata_d  = s_axis_tdata;
                        tkeep_d  = s_axis_tkeep;
                        tuser_d  = s_axis_tuser;
                        tlast_d  = s_axis_tlast;
                        tvalid_d = 1'b1;
                        tuser_d[DST_PORT_POS +: 8] = i_meta_oport;
                        if (is_rewrite) begin
                            tdata_d[255:208] = i_meta_dmac;
                            tdata_d[207:160] = smac;
                        end
                    end
                    if (s_axis_tlast) begin
                        state_d = ST_WORD1;
                    end else if (is_drop) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    tdata_d  = s_axis_tdata;
                    tkeep_d  = s_axis_tkeep;
                    tuser_d  = s_axis_tuser;
                    tlast_d  = s_axis_tlast;
                    tvalid_d = 1'b1;
                    tuser_d[DST_PORT_POS +: 8] = oport_q;
                    if (s_axis_tlast) begin
                        state_d = ST_WORD1;
                    end
                end
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        state_d = ST_WORD1;
                    end
                end
                default: state_d = ST_WORD1;
            endcase
        end
    end

`ifdef ETH_TX_STATS_EN
    always_comb begin
        cnt_rw_d   = cnt_rw_q;
        cnt_cpu_d  = cnt_cpu_q;
        cnt_drop_d = cnt_drop_q;
        if (in_hs && (state_q == ST_WORD1)) begin
            if (is_rewrite) begin
                cnt_rw_d = cnt_rw_q + 32'd1;
            end else if (is_cpu) begin
                cnt_cpu_d = cnt_cpu_q + 32'd1;
            end else begin
                cnt_drop_d = cnt_drop_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_rw_q   <= '0;
            cnt_cpu_q  <= '0;
            cnt_drop_q <= '0;
        end else begin
            cnt_rw_q   <= cnt_rw_d;
            cnt_cpu_q  <= cnt_cpu_d;
            cnt_drop_q <= cnt_drop_d;
        end
    end

    assign o_cnt_rewritten = cnt_rw_q;
    assign o_cnt_cpu       = cnt_cpu_q;
    assign o_cnt_dropped   = cnt_drop_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_WORD1;
            oport_q  <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            oport_q  <= oport_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign s_axis_tready = in_ready;
    assign o_meta_rd     = meta_rd;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_eth_tx_rewrite.sv
// tb/tb_eth_tx_rewrite.sv - scoreboard bench for eth_tx_rewrite.
module tb_eth_tx_rewrite;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] s_axis_tdata = '0;
    logic [31:0]  s_axis_tkeep = '0;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic [47:0]  i_meta_dmac = '0;
    logic [7:0]   i_meta_oport = '0;
    logic         i_meta_drop = 1'b0;
    logic         i_meta_valid = 1'b0;
    logic         o_meta_rd;
    logic [47:0]  i_mac0 = 48'h02AABBCCDD00;
    logic [47:0]  i_mac1 = 48'h02AABBCCDD01;
    logic [47:0]  i_mac2 = 48'h02AABBCCDD02;
    logic [47:0]  i_mac3 = 48'h02AABBCCDD03;
`ifdef ETH_TX_STATS_EN
    logic [31:0]  o_cnt_rewritten, o_cnt_cpu, o_cnt_dropped;
`endif

    eth_tx_rewrite dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .i_meta_dmac(i_meta_dmac), .i_meta_oport(i_meta_oport), .i_meta_drop(i_meta_drop),
        .i_meta_valid(i_meta_valid), .o_meta_rd(o_meta_rd),
        .i_mac0(i_mac0), .i_mac1(i_mac1), .i_mac2(i_mac2), .i_mac3(i_mac3)
`ifdef ETH_TX_STATS_EN
        , .o_cnt_rewritten(o_cnt_rewritten), .o_cnt_cpu(o_cnt_cpu), .o_cnt_dropped(o_cnt_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] dmac;
        logic [7:0]  oport;
        logic        drop;
    } meta_t;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    meta_t mq[$];
    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    pops = 0;
    logic  rd_pend = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Metadata FIFO model: pop when the DUT pulsed o_meta_rd in the previous cycle.
    always @(posedge clk) begin
        if (rd_pend) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else chk("meta_pop_empty", 1'b1, 1'b0);
        end
        #2;
        if (mq.size() > 0) begin
            i_meta_valid = 1'b1;
            i_meta_dmac  = mq[0].dmac;
            i_meta_oport = mq[0].oport;
            i_meta_drop  = mq[0].drop;
        end else begin
            i_meta_valid = 1'b0;
        end
    end

    // Monitor: compares presented beats against the scoreboard and checks stall stability.
    logic         stall_prev = 1'b0;
    logic [255:0] prev_d;
    logic [127:0] prev_u;
    logic [31:0]  prev_k;
    logic         prev_l;
    always @(negedge clk) begin
        beat_t e;
        rd_pend = o_meta_rd;
        if (o_meta_rd) pops++;
        if (stall_prev) begin
            chk("stall_valid", m_axis_tvalid, 1'b1);
            chk("stall_data", {m_axis_tdata}, {prev_d});
            chk("stall_side", {m_axis_tuser, m_axis_tkeep, m_axis_tlast}, {prev_u, prev_k, prev_l});
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", m_axis_tdata, 256'h0);
            end else begin
                e = sb.pop_front();
                chk("beat_data", m_axis_tdata, e.d);
                chk("beat_side", {m_axis_tuser, m_axis_tkeep, m_axis_tlast}, {e.u, e.k, e.l});
            end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_d = m_axis_tdata;
        prev_u = m_axis_tuser;
        prev_k = m_axis_tkeep;
        prev_l = m_axis_tlast;
    end

    // Caller is at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u,
                        input logic l, input logic chk_imm);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        if (chk_imm) chk("ready_immediate", s_axis_tready, 1'b1);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_axis_tready) chk("ready_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic expect_beat(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u,
                               input logic l);
        beat_t b;
        b.d = d; b.k = k; b.u = u; b.l = l;
        sb.push_back(b);
    endtask

    task automatic push_meta(input logic [47:0] dmac, input logic [7:0] oport, input logic drop);
        meta_t m;
        m.dmac = dmac; m.oport = oport; m.drop = drop;
        mq.push_back(m);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk(input logic [31:0] s);
        return {s, ~s, s ^ 32'h5A5A5A5A, s + 32'd1, s, ~s, s ^ 32'hA5A5A5A5, s + 32'd7};
    endfunction

    function automatic logic [127:0] dst(input logic [127:0] u, input logic [7:0] p);
        logic [127:0] r = u;
        r[31:24] = p;
        return r;
    endfunction

    function automatic logic [255:0] hdr(input logic [255:0] d, input logic [47:0] da,
                                         input logic [47:0] sa);
        logic [255:0] r = d;
        r[255:208] = da;
        r[207:160] = sa;
        return r;
    endfunction

    localparam logic [127:0] U0 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
    localparam logic [31:0]  KF = 32'hFFFF_FFFF;
    localparam logic [31:0]  KL = 32'h0000_FFFF;

    initial begin
        logic [255:0] w1, w2, w3, w4;
        logic [3:0]   pat;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, 256'h0);
        chk("rst_side", {m_axis_tuser, m_axis_tkeep, m_axis_tlast}, 161'h0);
        chk("rst_meta_rd", o_meta_rd, 1'b0);
        chk("rst_ready_nometa", s_axis_tready, 1'b0);
        @(posedge clk);
        #1;

        // Rewrite via port bit 2 (MAC1), 3 words, IPv4 ethertype.
        w1 = mk(32'h1000_0001);
        w1[159:144] = 16'h0800;
        w2 = mk(32'h1000_0002);
        w3 = mk(32'h1000_0003);
        push_meta(48'h112233445566, 8'h04, 1'b0);
        expect_beat({48'h112233445566, 48'h02AABBCCDD01, w1[159:0]}, KF, dst(U0, 8'h04), 1'b0);
        expect_beat(w2, KF, dst(U0, 8'h04), 1'b0);
        expect_beat(w3, KL, dst(U0, 8'h04), 1'b1);
        send(w1, KF, U0, 1'b0, 1'b0);
        send(w2, KF, U0, 1'b0, 1'b0);
        send(w3, KL, U0, 1'b1, 1'b0);
        drain();
        chk("pops_rewrite", pops, 1);

        // CPU port: header untouched, only tuser dst field.
        push_meta(48'hDEADDEADDEAD, 8'h02, 1'b0);
        expect_beat(w1, KF, dst(U0, 8'h02), 1'b0);
        expect_beat(w2, KF, dst(U0, 8'h02), 1'b0);
        expect_beat(w3, KL, dst(U0, 8'h02), 1'b1);
        send(w1, KF, U0, 1'b0, 1'b0);
        send(w2, KF, U0, 1'b0, 1'b0);
        send(w3, KL, U0, 1'b1, 1'b0);
        drain();
        chk("pops_cpu", pops, 2);

        // Drop flag on a 4-word packet, then a 1-word packet to MAC0.
        push_meta(48'h0000000000AA, 8'h01, 1'b1);
        push_meta(48'hA1A2A3A4A5A6, 8'h01, 1'b0);
        for (int i = 0; i < 4; i++) send(mk(32'h2000_0000 + i), KF, U0, i == 3, 1'b1);
        w4 = mk(32'h3000_0000);
        expect_beat(hdr(w4, 48'hA1A2A3A4A5A6, 48'h02AABBCCDD00), KL, dst(U0, 8'h01), 1'b1);
        send(w4, KL, U0, 1'b1, 1'b1);
        drain();
        chk("pops_drop", pops, 4);

        // Two MAC bits set is dropped; back-to-back single word to MAC3.
        push_meta(48'h0000000000BB, 8'h05, 1'b0);
        push_meta(48'hB1B2B3B4B5B6, 8'h40, 1'b0);
        expect_beat(hdr(w4, 48'hB1B2B3B4B5B6, 48'h02AABBCCDD03), KL, dst(U0, 8'h40), 1'b1);
        send(w4, KL, U0, 1'b1, 1'b1);
        send(w4, KL, U0, 1'b1, 1'b1);
        drain();
        chk("pops_b2b", pops, 6);

        // Input waits on empty metadata FIFO.
        s_axis_tdata  = w2;
        s_axis_tkeep  = KL;
        s_axis_tuser  = U0;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nometa_ready", s_axis_tready, 1'b0);
            chk("nometa_tvalid", m_axis_tvalid, 1'b0);
        end
        chk("nometa_pops", pops, 6);
        @(posedge clk);
        #1;
        push_meta(48'hC1C2C3C4C5C6, 8'h08, 1'b0);
        expect_beat(w2, KL, dst(U0, 8'h08), 1'b1);
        @(negedge clk);
        chk("meta_arrival_ready", s_axis_tready, 1'b1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        drain();
        chk("pops_nometa", pops, 7);

        // Output backpressure 1,0,0,1 during a 4-word packet to MAC2.
        push_meta(48'hD1D2D3D4D5D6, 8'h10, 1'b0);
        expect_beat(hdr(w1, 48'hD1D2D3D4D5D6, 48'h02AABBCCDD02), KF, dst(U0, 8'h10), 1'b0);
        expect_beat(w2, KF, dst(U0, 8'h10), 1'b0);
        expect_beat(w3, KF, dst(U0, 8'h10), 1'b0);
        expect_beat(w4, KL, dst(U0, 8'h10), 1'b1);
        pat = 4'b1001;
        fork
            begin
                send(w1, KF, U0, 1'b0, 1'b0);
                send(w2, KF, U0, 1'b0, 1'b0);
                send(w3, KF, U0, 1'b0, 1'b0);
                send(w4, KL, U0, 1'b1, 1'b0);
            end
            begin
                @(posedge clk);
                for (int i = 3; i >= 0; i--) begin
                    @(posedge clk);
                    #1 m_axis_tready = pat[i];
                end
                @(posedge clk);
                #1 m_axis_tready = 1'b1;
            end
        join
        drain();
        chk("pops_bp", pops, 8);

        // Reset in the middle of a packet body.
        push_meta(48'hE1E2E3E4E5E6, 8'h04, 1'b0);
        expect_beat(hdr(w1, 48'hE1E2E3E4E5E6, 48'h02AABBCCDD01), KF, dst(U0, 8'h04), 1'b0);
        expect_beat(w2, KF, dst(U0, 8'h04), 1'b0);
        send(w1, KF, U0, 1'b0, 1'b0);
        send(w2, KF, U0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_tvalid", m_axis_tvalid, 1'b0);
        chk("post_reset_sb", sb.size(), 0);
`ifdef ETH_TX_STATS_EN
        chk("post_reset_counters", {o_cnt_rewritten, o_cnt_cpu, o_cnt_dropped}, 96'h0);
`endif
        @(posedge clk);
        #1;
        push_meta(48'hF1F2F3F4F5F6, 8'h20, 1'b0);
        expect_beat(w3, KL, dst(U0, 8'h20), 1'b1);
        send(w3, KL, U0, 1'b1, 1'b0);
        drain();
        chk("pops_after_reset", pops, 10);
`ifdef ETH_TX_STATS_EN
        chk("counters_after_cpu", {o_cnt_rewritten, o_cnt_cpu, o_cnt_dropped}, {32'd0, 32'd1, 32'd0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
